// File: rtl/rms_norm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rms_norm
// Purpose  : RMSNorm apply step. Computes one fixed-point reciprocal of the
//            supplied RMS with a serial restoring divider, then scales the
//            latched vector one element per cycle with a single multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module rms_norm #(
  parameter int ARR_WIDTH = 8,
  parameter int FXP_N     = 16,
  parameter int FXP_FRAC  = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                start,
  input  logic [ARR_WIDTH-1:0][FXP_N-1:0]     input_arr,
  input  logic [FXP_N-1:0]                    rms_in,
  output logic [ARR_WIDTH-1:0][FXP_N-1:0]     norm_out,
  output logic                                busy,
  output logic                                done,
  output logic                                div_zero
);

  // Quotient bits produced by the divider: numerator is 2^(2*FXP_FRAC).
  localparam int QW = 2 * FXP_FRAC + 1;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam int IW = (ARR_WIDTH > 1) ? $clog2(ARR_WIDTH) : 1;
  localparam int SW = QW + FXP_N;

  localparam logic [FXP_N-1:0] POS_MAX = {1'b0, {(FXP_N-1){1'b1}}};
  localparam logic [FXP_N-1:0] NEG_MIN = {1'b1, {(FXP_N-1){1'b0}}};
  localparam logic signed [2*FXP_N-1:0] P_MAX = {{(FXP_N+1){1'b0}}, {(FXP_N-1){1'b1}}};
  localparam logic signed [2*FXP_N-1:0] P_MIN = {{(FXP_N+1){1'b1}}, {(FXP_N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECIP = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                            state_q;
  logic [ARR_WIDTH-1:0][FXP_N-1:0]   vec_q;
  logic [FXP_N-1:0]                  rms_q;
  logic [FXP_N:0]                    rem_q;
  logic [QW-1:0]                     quot_q;
  logic [FXP_N-1:0]                  recip_q;
  logic [CW-1:0]                     bit_cnt_q;
  logic [IW-1:0]                     idx_q;
  logic [ARR_WIDTH-1:0][FXP_N-1:0]   norm_q;
  logic                              busy_q;
  logic                              done_q;
  logic                              dz_q;

  logic                              num_bit_d;
  logic [FXP_N:0]                    rem_sh_d;
  logic                              q_bit_d;
  logic [FXP_N:0]                    rem_d;
  logic [QW-1:0]                     quot_d;
  logic [SW-1:0]                     quot_ext_d;
  logic [FXP_N-1:0]                  recip_d;
  logic signed [FXP_N-1:0]           elem_d;
  logic signed [2*FXP_N-1:0]         prod_d;
  logic signed [2*FXP_N-1:0]         shift_d;
  logic [FXP_N-1:0]                  scaled_d;
  logic                              nonpos_d;

  // Divider step and element scaling datapath, shared by the FSM below.
  always_comb begin
    // The numerator is a single 1 followed by zeros, so only the first
    // shifted-in bit is set.
    num_bit_d  = (bit_cnt_q == '0);
    rem_sh_d   = (rem_q << 1) | {{FXP_N{1'b0}}, num_bit_d};
    q_bit_d    = (rem_sh_d >= {1'b0, rms_q});
    rem_d      = q_bit_d ? (rem_sh_d - {1'b0, rms_q}) : rem_sh_d;
    quot_d     = (quot_q << 1) | {{(QW-1){1'b0}}, q_bit_d};
    quot_ext_d = SW'(quot_d);
    recip_d    = (quot_ext_d > SW'(POS_MAX)) ? POS_MAX : quot_ext_d[FXP_N-1:0];

    // Reciprocal is non-negative, so it enters the multiply zero-extended.
    elem_d   = vec_q[idx_q];
    prod_d   = (2*FXP_N)'(elem_d) * (2*FXP_N)'($signed({1'b0, recip_q}));
    shift_d  = prod_d >>> FXP_FRAC;
    if (shift_d > P_MAX) begin
      scaled_d = POS_MAX;
    end else if (shift_d < P_MIN) begin
      scaled_d = NEG_MIN;
    end else begin
      scaled_d = shift_d[FXP_N-1:0];
    end

    nonpos_d = rms_in[FXP_N-1] | (rms_in == '0);
  end

  // Control FSM with registered outputs; every update is gated by enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      rms_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      recip_q   <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      norm_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            vec_q     <= input_arr;
            rms_q     <= rms_in;
            rem_q     <= '0;
            quot_q    <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            if (nonpos_d) begin
              // No valid reciprocal: report it and publish an all-zero vector.
              dz_q    <= 1'b1;
              norm_q  <= '0;
              state_q <= S_DONE;
            end else begin
              dz_q    <= 1'b0;
              state_q <= S_RECIP;
            end
          end
        end
        S_RECIP: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          if (bit_cnt_q == CW'(QW - 1)) begin
            recip_q <= recip_d;
            idx_q   <= '0;
            state_q <= S_SCALE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_SCALE: begin
          norm_q[idx_q] <= scaled_d;
          if (idx_q == IW'(ARR_WIDTH - 1)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          // The zero path arrives here with done low and raises it one
          // enabled edge later; the pulse always lasts one enabled cycle.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign norm_out = norm_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_rms_norm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rms_norm
// Purpose  : Scoreboard bench for rms_norm with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rms_norm;

  localparam int A = 8;
  localparam int N = 16;
  localparam int F = 8;
  localparam longint MAXV = (longint'(1) <<< (N-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (N-1));

  typedef logic [A-1:0][N-1:0] vec_t;
  typedef struct {
    vec_t   norm;
    logic   dz;
    longint lat;
    longint raw_lat;
    longint s_en;
    longint s_raw;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  vec_t          input_arr = '0;
  logic [N-1:0]  rms_in = '0;
  vec_t          norm_out;
  logic          busy;
  logic          done;
  logic          div_zero;

  rms_norm #(.ARR_WIDTH(A), .FXP_N(N), .FXP_FRAC(F)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .input_arr(input_arr), .rms_in(rms_in), .norm_out(norm_out),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  longint en_cnt = 0;
  longint raw_cnt = 0;
  always @(posedge clk) begin
    raw_cnt <= raw_cnt + 1;
    if (enable && rst_n) en_cnt <= en_cnt + 1;
  end

  int     n_checks = 0;
  int     n_pass = 0;
  exp_t   sb[$];
  logic   done_prev = 1'b0;
  longint rise_en = 0;

  task automatic chk(input string name, input logic [A*N-1:0] act, input logic [A*N-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: reciprocal = floor(2^(2F)/rms) clipped, then floor(x*recip/2^F) clipped.
  function automatic exp_t model(input vec_t v, input logic [N-1:0] rms);
    exp_t e;
    longint r, recip, x, p, q, d;
    e.norm = '0; e.dz = 1'b0; e.lat = 0; e.raw_lat = -1; e.s_en = 0; e.s_raw = 0;
    r = longint'($signed(rms));
    if (r <= 0) begin
      e.dz  = 1'b1;
      e.lat = 1;
      return e;
    end
    e.lat = 2*F + 1 + A;
    recip = (longint'(1) << (2*F)) / r;
    if (recip > MAXV) recip = MAXV;
    d = longint'(1) << F;
    for (int i = 0; i < A; i++) begin
      x = longint'($signed(v[i]));
      p = x * recip;
      q = (p >= 0) ? (p / d) : -((-p + d - 1) / d);
      if (q > MAXV) q = MAXV;
      if (q < MINV) q = MINV;
      e.norm[i] = q[N-1:0];
    end
    return e;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < A; i++) begin
      v[i] = ($urandom_range(0, 1) != 0) ? N'($urandom) : N'($urandom_range(0, 1023) - 512);
    end
    return v;
  endfunction

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  // Drive one accepted request and record its expected response.
  task automatic issue(input vec_t v, input logic [N-1:0] r, input longint raw_lat);
    exp_t e;
    e = model(v, r);
    e.raw_lat = raw_lat;
    e.s_en  = en_cnt;
    e.s_raw = raw_cnt;
    input_arr = v;
    rms_in    = r;
    start     = 1'b1;
    enable    = 1'b1;
    sb.push_back(e);
    cyc();
    start     = 1'b0;
    input_arr = rand_vec();
    rms_in    = N'($urandom);
    chk("busy_after_start", busy, 1'b1);
    chk("div_zero_after_start", div_zero, e.dz);
  endtask

  task automatic finish_run(input int bound, input bit stall, input bit hold);
    for (int i = 0; i < bound && sb.size() != 0; i++) begin
      enable = stall ? ($urandom_range(0, 7) != 0) : 1'b1;
      cyc();
    end
    chk("done_timeout", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    if (hold) begin
      enable = 1'b0;
      cyc();
      cyc();
      chk("done_held_while_disabled", done, 1'b1);
    end
    enable = 1'b1;
    cyc();
    chk("busy_back_idle", busy, 1'b0);
    chk("done_one_cycle", done, 1'b0);
  endtask

  // Monitor: compare each done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 expected no pending request");
        end else begin
          exp_t it;
          it = sb.pop_front();
          chk("norm_out", norm_out, it.norm);
          chk("div_zero", div_zero, it.dz);
          chk("latency", en_cnt - it.s_en - 1, it.lat);
          if (it.raw_lat >= 0) chk("raw_latency", raw_cnt - it.s_raw - 1, it.raw_lat);
          chk("busy_at_done", busy, 1'b1);
        end
        rise_en = en_cnt;
      end else if (done && done_prev) begin
        chk("done_width", en_cnt, rise_en);
      end
      done_prev = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;

    rst_n = 1'b0; enable = 1'b0;
    repeat (3) cyc();
    chk("reset_norm_out", norm_out, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_div_zero", div_zero, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Identity with RMS of 1.0
    v = '0;
    v[0] = 16'h0100; v[1] = 16'hFF00; v[2] = 16'h0080; v[3] = 16'h0000;
    v[4] = 16'h7FFF; v[5] = 16'h8000; v[6] = 16'h0001; v[7] = 16'hFFFF;
    issue(v, 16'h0100, 25);
    finish_run(60, 1'b0, 1'b0);

    // Scaling by 1/2 with truncation toward negative infinity
    v = rand_vec();
    v[0] = 16'h0300; v[1] = 16'hFF00; v[2] = 16'h0001;
    issue(v, 16'h0200, 25);
    finish_run(60, 1'b0, 1'b0);

    // Reciprocal saturation
    v = rand_vec();
    v[0] = 16'h0100; v[1] = 16'h0200; v[2] = 16'hFF00; v[3] = 16'hFE00;
    issue(v, 16'h0001, 25);
    finish_run(60, 1'b0, 1'b0);

    // Zero and negative RMS
    issue(rand_vec(), 16'h0000, 1);
    finish_run(20, 1'b0, 1'b0);
    issue(rand_vec(), 16'h8000, 1);
    finish_run(20, 1'b0, 1'b0);
    issue(rand_vec(), 16'h0140, 25);
    finish_run(60, 1'b0, 1'b0);

    // Stalls mid-RECIP and mid-SCALE, with an ignored start during SCALE
    issue(rand_vec(), 16'h00C0, 33);
    repeat (5) cyc();
    enable = 1'b0;
    repeat (5) cyc();
    enable = 1'b1;
    repeat (14) cyc();
    input_arr = rand_vec();
    rms_in    = 16'h0100;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
    enable    = 1'b0;
    repeat (3) cyc();
    enable    = 1'b1;
    finish_run(60, 1'b0, 1'b1);

    // Reset in the middle of SCALE
    issue(rand_vec(), 16'h0180, -1);
    repeat (20) cyc();
    rst_n = 1'b0;
    #1;
    chk("midreset_norm_out", norm_out, '0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_done", done, 1'b0);
    chk("midreset_div_zero", div_zero, 1'b0);
    sb.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    issue(rand_vec(), 16'h0100, 25);
    finish_run(60, 1'b0, 1'b0);

    // Randomized requests with random stalls
    for (int k = 0; k < 40; k++) begin
      logic [N-1:0] r;
      case ($urandom_range(0, 3))
        0: r = ($urandom_range(0, 1) != 0) ? 16'h0000 : {1'b1, 15'($urandom)};
        1: r = N'($urandom_range(1, 31));
        2: r = N'($urandom_range(64, 1024));
        default: r = N'($urandom_range(1, 32767));
      endcase
      issue(rand_vec(), r, -1);
      finish_run(400, ($urandom_range(0, 1) != 0), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
